// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: decodes opcode/funct fields into datapath strobes.
// Define MC_STALL_EN to hold FETCH/MEMREAD/MEMWRITE until mem_ready.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    input  logic       sign,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state_q, state_d;
    logic   ready;

`ifdef MC_STALL_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign ready            = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    function automatic logic [2:0] alu_funct(input logic [2:0] f3, input logic op5, input logic f7);
        case (f3)
            3'b000:  return (op5 & f7) ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic s);
        case (f3)
            3'b000:  return z;
            3'b001:  return ~z;
            3'b100:  return s;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        illegal     = 1'b0;

        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ready;
                pc_write   = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jal target is formed here from OldPC + imm into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_funct(funct3, op[5], funct7);
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_funct(funct3, op[5], funct7);
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = branch_taken(funct3, zero, sign);
                state_d     = S_FETCH;
            end
            S_JAL: begin
                // PC <- ALUOut (target); ALU forms OldPC+4 for the following ALUWB.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ERROR: begin
                illegal = 1'b1;
                state_d = S_ERROR;
            end
            default: state_d = S_FETCH;
        endcase

        // Strobes drop the moment rst_n falls so an aborted instruction writes nothing.
        if (!rst_n) begin
            mem_req   = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign state = state_q;

endmodule
